// File: rtl/rstn_seq_if.sv
// Control/status bundle of the reset sequencer: scan bypass and software
// reset requests in, per-channel resets and the done flag out.
interface rstn_seq_if #(
  parameter int NUM_CH = 4
) ();
  logic              i_test_mode;
  logic              i_sw_rst;
  logic [NUM_CH-1:0] o_rstn;
  logic              o_done;

  modport master (
    output i_test_mode,
    output i_sw_rst,
    input  o_rstn,
    input  o_done
  );

  modport slave (
    input  i_test_mode,
    input  i_sw_rst,
    output o_rstn,
    output o_done
  );
endinterface

// File: rtl/rstn_seq.sv
// Reset synchroniser and sequencer: asserts every channel asynchronously and
// releases them one by one in index order, REL_DLY cycles apart.
module rstn_seq #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int REL_DLY     = 8
) (
  input  logic      i_clk,
  input  logic      i_rstn,
  rstn_seq_if.slave io
);
  localparam int CNT_W = $clog2(REL_DLY + 1);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REL_DLY - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    HOLD,
    SEQ,
    DONE
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state, w_stateNext;
  logic [CNT_W-1:0]       r_cnt, w_cntNext;
  logic [CH_W-1:0]        r_ch, w_chNext;
  logic                   r_swHold, w_swHoldNext;
  logic [NUM_CH-1:0]      r_rstn, w_rstnNext;
  logic                   r_done, w_doneNext;
  logic                   w_syncOk;
  logic                   w_syncArm;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Leaving HOLD on the very edge where sync_ok rises makes the first release
  // gap start at that edge, so channel k is released (k+1)*REL_DLY edges later.
  assign w_syncOk  = r_sync[SYNC_STAGES-1];
  assign w_syncArm = r_sync[SYNC_STAGES-2];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state  <= HOLD;
      r_cnt    <= '0;
      r_ch     <= '0;
      r_swHold <= 1'b0;
      r_rstn   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_ch     <= w_chNext;
      r_swHold <= w_swHoldNext;
      r_rstn   <= w_rstnNext;
      r_done   <= w_doneNext;
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_chNext     = r_ch;
    w_swHoldNext = r_swHold;
    w_rstnNext   = r_rstn;
    w_doneNext   = r_done;
    case (r_state)
      HOLD: begin
        // A software reset holds all outputs low for REL_DLY cycles; the
        // synchroniser is already settled then, so only the counter matters.
        if (r_swHold) begin
          if (r_cnt == CNT_LAST) begin
            w_stateNext  = SEQ;
            w_cntNext    = '0;
            w_chNext     = '0;
            w_swHoldNext = 1'b0;
          end else begin
            w_cntNext = r_cnt + CNT_W'(1);
          end
        end else if (w_syncArm && !w_syncOk) begin
          w_stateNext = SEQ;
          w_cntNext   = '0;
          w_chNext    = '0;
        end
      end
      SEQ: begin
        if (r_cnt == CNT_LAST) begin
          w_rstnNext[r_ch] = 1'b1;
          w_cntNext        = '0;
          if (r_ch == CH_LAST) begin
            w_doneNext  = 1'b1;
            w_stateNext = DONE;
          end else begin
            w_chNext = r_ch + CH_W'(1);
          end
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end
      DONE: begin
        if (io.i_sw_rst) begin
          w_rstnNext   = '0;
          w_doneNext   = 1'b0;
          w_stateNext  = HOLD;
          w_cntNext    = '0;
          w_swHoldNext = 1'b1;
        end
      end
      default: begin
        w_stateNext = HOLD;
      end
    endcase
  end

  // Scan bypass hands every output straight to the pin reset.
  assign io.o_rstn = io.i_test_mode ? {NUM_CH{i_rstn}} : r_rstn;
  assign io.o_done = io.i_test_mode ? i_rstn : r_done;
endmodule
